// File: rtl/rw_stage_commit.sv
// Register-writeback stage: selects the result, holds it until the register file takes it,
// and keeps a short history of committed writes for operand forwarding.
module rw_stage_commit #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned REG_AW    = 4,
  parameter int unsigned CTRL_W    = 22,
  parameter int unsigned LD_BIT    = 0,
  parameter int unsigned CALL_BIT  = 4,
  parameter int unsigned WB_BIT    = 5,
  parameter int unsigned RD_LSB    = 22,
  parameter int unsigned RA_IDX    = 15,
  parameter int unsigned FWD_DEPTH = 2,
  parameter int unsigned CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   pc_in,
  input  logic [XLEN-1:0]   ld_result,
  input  logic [XLEN-1:0]   alu_result,
  input  logic [31:0]       inst_in,
  input  logic [CTRL_W-1:0] control_in,
  input  logic              rf_ready,
  output logic              reg_write_en,
  output logic [REG_AW-1:0] reg_write_address,
  output logic [XLEN-1:0]   reg_write_data,
  input  logic [REG_AW-1:0] fwd_query_addr,
  output logic              fwd_hit,
  output logic [XLEN-1:0]   fwd_data,
  output logic [CNT_W-1:0]  retired_count
);

  logic              pending_q, pending_d;
  logic              we_q, we_d;
  logic [REG_AW-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   data_q, data_d;
  logic [CNT_W-1:0]  retired_q;

  logic              hist_v_q [FWD_DEPTH];
  logic [REG_AW-1:0] hist_a_q [FWD_DEPTH];
  logic [XLEN-1:0]   hist_d_q [FWD_DEPTH];

  logic is_ld, is_call, is_wb;
  logic commit, commit_eff, accept;
  logic [XLEN-1:0]   sel_data;
  logic [REG_AW-1:0] sel_addr;

  // Only part of the instruction and control buses matter here.
  logic unused_bits;
  assign unused_bits = ^{inst_in, control_in};

  assign is_ld   = control_in[LD_BIT];
  assign is_call = control_in[CALL_BIT];
  assign is_wb   = control_in[WB_BIT];

  assign sel_data = is_call ? (pc_in + XLEN'(4)) : (is_ld ? ld_result : alu_result);
  assign sel_addr = is_call ? REG_AW'(RA_IDX) : inst_in[RD_LSB +: REG_AW];

  // Non-writing entries retire without waiting on the register file.
  assign commit     = pending_q & (rf_ready | ~we_q);
  assign commit_eff = commit & ~flush;
  assign in_ready   = ~pending_q | commit;
  assign accept     = in_valid & in_ready & ~flush;

  always_comb begin
    pending_d = pending_q;
    we_d      = we_q;
    addr_d    = addr_q;
    data_d    = data_q;
    if (flush) begin
      pending_d = 1'b0;
    end else if (accept) begin
      pending_d = 1'b1;
      we_d      = is_wb | is_call;
      addr_d    = sel_addr;
      data_d    = sel_data;
    end else if (commit) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      retired_q <= '0;
    end else begin
      pending_q <= pending_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      if (commit_eff) retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Slot 0 holds the youngest committed write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < FWD_DEPTH; i++) begin
        hist_v_q[i] <= 1'b0;
        hist_a_q[i] <= '0;
        hist_d_q[i] <= '0;
      end
    end else if (flush) begin
      for (int unsigned i = 0; i < FWD_DEPTH; i++) hist_v_q[i] <= 1'b0;
    end else if (commit_eff && we_q) begin
      for (int unsigned i = FWD_DEPTH - 1; i >= 1; i--) begin
        hist_v_q[i] <= hist_v_q[i-1];
        hist_a_q[i] <= hist_a_q[i-1];
        hist_d_q[i] <= hist_d_q[i-1];
      end
      hist_v_q[0] <= 1'b1;
      hist_a_q[0] <= addr_q;
      hist_d_q[0] <= data_q;
    end
  end

  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (pending_q && we_q && (addr_q == fwd_query_addr)) begin
      fwd_hit  = 1'b1;
      fwd_data = data_q;
    end else begin
      for (int unsigned i = 0; i < FWD_DEPTH; i++) begin
        if (!fwd_hit && hist_v_q[i] && (hist_a_q[i] == fwd_query_addr)) begin
          fwd_hit  = 1'b1;
          fwd_data = hist_d_q[i];
        end
      end
    end
  end

  assign reg_write_en      = pending_q & we_q;
  assign reg_write_address = addr_q;
  assign reg_write_data    = data_q;
  assign retired_count     = retired_q;

endmodule

// File: tb/tb_rw_stage_commit.sv
// Directed bench for rw_stage_commit with a 4-bit retired counter to reach wrap quickly.
module tb_rw_stage_commit;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 4;
  localparam int unsigned CTRL_W = 22;
  localparam int unsigned CNT_W  = 4;

  localparam logic [CTRL_W-1:0] C_LD   = 22'h000001;
  localparam logic [CTRL_W-1:0] C_CALL = 22'h000010;
  localparam logic [CTRL_W-1:0] C_WB   = 22'h000020;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   pc_in;
  logic [XLEN-1:0]   ld_result;
  logic [XLEN-1:0]   alu_result;
  logic [31:0]       inst_in;
  logic [CTRL_W-1:0] control_in;
  logic              rf_ready;
  logic              reg_write_en;
  logic [REG_AW-1:0] reg_write_address;
  logic [XLEN-1:0]   reg_write_data;
  logic [REG_AW-1:0] fwd_query_addr;
  logic              fwd_hit;
  logic [XLEN-1:0]   fwd_data;
  logic [CNT_W-1:0]  retired_count;

  int passes = 0;
  int total  = 0;

  rw_stage_commit #(.CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .pc_in            (pc_in),
    .ld_result        (ld_result),
    .alu_result       (alu_result),
    .inst_in          (inst_in),
    .control_in       (control_in),
    .rf_ready         (rf_ready),
    .reg_write_en     (reg_write_en),
    .reg_write_address(reg_write_address),
    .reg_write_data   (reg_write_data),
    .fwd_query_addr   (fwd_query_addr),
    .fwd_hit          (fwd_hit),
    .fwd_data         (fwd_data),
    .retired_count    (retired_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic v, input logic [CTRL_W-1:0] c, input logic [3:0] rd,
                         input logic [31:0] alu, input logic [31:0] ld, input logic [31:0] pc);
    in_valid   = v;
    control_in = c;
    inst_in    = 32'(rd) << 22;
    alu_result = alu;
    ld_result  = ld;
    pc_in      = pc;
  endtask

  task automatic check_wr(input string tag, input logic en, input logic [3:0] a,
                          input logic [31:0] d);
    check({tag, "_en"}, 64'(reg_write_en), 64'(en));
    if (en) begin
      check({tag, "_addr"}, 64'(reg_write_address), 64'(a));
      check({tag, "_data"}, 64'(reg_write_data), 64'(d));
    end
  endtask

  task automatic check_fwd(input string tag, input logic [3:0] q, input logic hit,
                           input logic [31:0] d);
    fwd_query_addr = q;
    #1;
    check({tag, "_hit"}, 64'(fwd_hit), 64'(hit));
    check({tag, "_data"}, 64'(fwd_data), 64'(d));
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; rf_ready = 1'b1; fwd_query_addr = '0;
    present(1'b0, '0, 4'd0, 32'd0, 32'd0, 32'd0);
    tick(); tick();
    check_wr("reset", 1'b0, 4'd0, 32'd0);
    check("reset_addr", 64'(reg_write_address), 64'd0);
    check("reset_data", 64'(reg_write_data), 64'd0);
    check("reset_cnt", 64'(retired_count), 64'd0);
    rst = 1'b1;
    #1;
    check("reset_ready", 64'(in_ready), 64'd1);

    // ALU write r3=5
    present(1'b1, C_WB, 4'd3, 32'd5, 32'd0, 32'd0);
    tick();
    check_wr("alu", 1'b1, 4'd3, 32'd5);
    check("alu_cnt0", 64'(retired_count), 64'd0);
    present(1'b0, '0, 4'd0, 32'd0, 32'd0, 32'd0);
    tick();
    check_wr("alu_done", 1'b0, 4'd0, 32'd0);
    check("alu_cnt1", 64'(retired_count), 64'd1);

    // Load then call back-to-back
    present(1'b1, C_LD | C_WB, 4'd6, 32'h55, 32'hA, 32'd0);
    tick();
    check_wr("load", 1'b1, 4'd6, 32'hA);
    present(1'b1, C_CALL, 4'd2, 32'h55, 32'hA, 32'h100);
    #1;
    check("b2b_ready", 64'(in_ready), 64'd1);
    tick();
    check_wr("call", 1'b1, 4'd15, 32'h104);
    check("call_cnt", 64'(retired_count), 64'd2);
    present(1'b0, '0, 4'd0, 32'd0, 32'd0, 32'd0);
    tick();
    check("call_cnt_done", 64'(retired_count), 64'd3);

    // Stall r7 while r8 waits upstream
    rf_ready = 1'b0;
    present(1'b1, C_WB, 4'd7, 32'h77, 32'd0, 32'd0);
    tick();
    present(1'b1, C_WB, 4'd8, 32'h88, 32'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      check_wr("stall", 1'b1, 4'd7, 32'h77);
      check("stall_ready", 64'(in_ready), 64'd0);
      check("stall_cnt", 64'(retired_count), 64'd3);
      tick();
    end
    rf_ready = 1'b1;
    #1;
    check("release_ready", 64'(in_ready), 64'd1);
    tick();
    check("release_cnt", 64'(retired_count), 64'd4);
    check_wr("release_next", 1'b1, 4'd8, 32'h88);
    present(1'b0, '0, 4'd0, 32'd0, 32'd0, 32'd0);
    tick();
    check("release_cnt2", 64'(retired_count), 64'd5);

    // Forwarding: r3=5 committed, r3=7 pending
    present(1'b1, C_WB, 4'd3, 32'd5, 32'd0, 32'd0);
    tick();
    present(1'b1, C_WB, 4'd3, 32'd7, 32'd0, 32'd0);
    tick();
    present(1'b0, '0, 4'd0, 32'd0, 32'd0, 32'd0);
    check_fwd("fwd_pend", 4'd3, 1'b1, 32'd7);
    tick();
    check("fwd_cnt", 64'(retired_count), 64'd7);
    check_fwd("fwd_hist", 4'd3, 1'b1, 32'd7);
    check_fwd("fwd_miss", 4'd9, 1'b0, 32'd0);
    check_fwd("fwd_aged", 4'd8, 1'b0, 32'd0);

    // Flush with pending r4 and an incoming entry
    rf_ready = 1'b0;
    present(1'b1, C_WB, 4'd4, 32'h44, 32'd0, 32'd0);
    tick();
    check_fwd("flush_pre", 4'd4, 1'b1, 32'h44);
    flush = 1'b1; rf_ready = 1'b1;
    present(1'b1, C_WB, 4'd5, 32'h55, 32'd0, 32'd0);
    tick();
    flush = 1'b0;
    present(1'b0, '0, 4'd0, 32'd0, 32'd0, 32'd0);
    check_wr("flush", 1'b0, 4'd0, 32'd0);
    check("flush_cnt", 64'(retired_count), 64'd7);
    check_fwd("flush_q4", 4'd4, 1'b0, 32'd0);
    check_fwd("flush_q3", 4'd3, 1'b0, 32'd0);
    tick();
    check_wr("flush_after", 1'b0, 4'd0, 32'd0);
    check("flush_cnt2", 64'(retired_count), 64'd7);

    // Counter wrap from a fresh reset: 17 back-to-back commits
    rst = 1'b0;
    #1;
    rst = 1'b1;
    check("wrap_start", 64'(retired_count), 64'd0);
    for (int i = 0; i < 17; i++) begin
      present(1'b1, C_WB, 4'(i), 32'(i + 100), 32'd0, 32'd0);
      tick();
    end
    check("wrap_zero", 64'(retired_count), 64'd0);
    check_wr("wrap_last", 1'b1, 4'd0, 32'd116);
    present(1'b0, '0, 4'd0, 32'd0, 32'd0, 32'd0);
    tick();
    check("wrap_one", 64'(retired_count), 64'd1);

    // Async reset during a stall
    rf_ready = 1'b0;
    present(1'b1, C_WB, 4'd9, 32'h99, 32'd0, 32'd0);
    tick();
    present(1'b0, '0, 4'd0, 32'd0, 32'd0, 32'd0);
    check_wr("pre_rst", 1'b1, 4'd9, 32'h99);
    #2;
    rst = 1'b0;
    #1;
    check("rst_en", 64'(reg_write_en), 64'd0);
    check("rst_addr", 64'(reg_write_address), 64'd0);
    check("rst_data", 64'(reg_write_data), 64'd0);
    check("rst_cnt", 64'(retired_count), 64'd0);
    rst = 1'b1;
    rf_ready = 1'b1;
    tick();
    check_wr("post_rst", 1'b0, 4'd0, 32'd0);
    check("post_rst_cnt", 64'(retired_count), 64'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
